// File: rtl/cache_types.sv
// Shared types for the cache subsystem: arbiter state encoding and well-known port indices.
package cache_types;

    typedef enum logic {
        arb_idle = 1'b0,
        arb_busy = 1'b1
    } arb_state_t;

    localparam int PORT_ICACHE = 0;
    localparam int PORT_DCACHE = 1;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active requester strictly after 'last', wrapping.
module rr_pick #(
    parameter  int NPORT = 2,
    localparam int IW    = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] active,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    grant,
    output logic             any
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        any   = |active;
        // Scan last+1 .. last+NPORT so 'last' itself has the lowest priority.
        for (int k = 1; k <= NPORT; k++) begin
            idx = IW'((int'(last) + k) % NPORT);
            if (!found && active[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between NPORT cache miss ports,
// one transaction in flight, with a sticky watchdog on stalled memory responses.
module cache_mem_arbiter
    import cache_types::*;
#(
    parameter int NPORT   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NPORT-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NPORT-1:0]              req_read,
    input  logic [NPORT-1:0]              req_write,
    input  logic [NPORT-1:0][LINE_W-1:0]  req_wdata,
    output logic [NPORT-1:0][LINE_W-1:0]  req_rdata,
    output logic [NPORT-1:0]              req_resp,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [LINE_W-1:0]             mem_wdata,
    input  logic [LINE_W-1:0]             mem_rdata,
    input  logic                          mem_resp,
    output logic                          err_timeout
);

    localparam int IW = $clog2(NPORT);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Handshake: a requester holds addr/read/write/wdata stable until the single-cycle
    // req_resp; memory likewise sees its request held until the single-cycle mem_resp.

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_d;

    logic [NPORT-1:0] active;
    logic [IW-1:0]    pick_grant;
    logic             pick_any;

    assign active = req_read | req_write;

    rr_pick #(.NPORT(NPORT)) u_rr_pick (
        .active (active),
        .last   (last_q),
        .grant  (pick_grant),
        .any    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            arb_idle: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    state_d = arb_busy;
                end
            end
            arb_busy: begin
                if (mem_resp) begin
                    last_d  = grant_q;
                    state_d = arb_idle;
                end
            end
            default: state_d = arb_idle;
        endcase
    end

    // Watchdog counts BUSY cycles; the flag rises in the cycle the count reaches TIMEOUT.
    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_timeout;
        if (state_q == arb_busy) begin
            if (mem_resp) begin
                wdog_d = '0;
            end else if (wdog_q != '1) begin
                wdog_d = wdog_q + 1'b1;
            end
            if ((TIMEOUT != 0) && !mem_resp && (wdog_d == WW'(TIMEOUT))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= arb_idle;
            grant_q     <= '0;
            last_q      <= IW'(NPORT - 1);
            wdog_q      <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wdog_q      <= wdog_d;
            err_timeout <= err_d;
        end
    end

    // Memory side is fed only from registered grant, so IDLE has no req_* -> mem_* path.
    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        req_resp  = '0;
        if (state_q == arb_busy) begin
            mem_addr          = req_addr[grant_q];
            mem_read          = req_read[grant_q];
            mem_write         = req_write[grant_q];
            mem_wdata         = req_wdata[grant_q];
            req_resp[grant_q] = mem_resp;
        end
    end

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            req_rdata[i] = mem_rdata;
        end
    end

    for (genvar i = 0; i < NPORT; i++) begin : g_port_chk
        a_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
            !(req_read[i] && req_write[i]));
    end

    a_hold_req: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == arb_busy && !mem_resp) |-> active[grant_q]);

    a_no_idle_resp: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == arb_idle) |-> !mem_resp);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: single read, tie-break, writeback+fill, fairness,
// reset mid-transaction and watchdog, with hand-computed expectations.
module tb_cache_mem_arbiter;

    localparam int NPORT   = 2;
    localparam int TIMEOUT = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NPORT-1:0][31:0]   req_addr;
    logic [NPORT-1:0]         req_read;
    logic [NPORT-1:0]         req_write;
    logic [NPORT-1:0][255:0]  req_wdata;
    logic [NPORT-1:0][255:0]  req_rdata;
    logic [NPORT-1:0]         req_resp;
    logic [31:0]              mem_addr;
    logic                     mem_read;
    logic                     mem_write;
    logic [255:0]             mem_wdata;
    logic [255:0]             mem_rdata;
    logic                     mem_resp;
    logic                     err_timeout;

    int n_checks = 0;
    int n_bad    = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    cache_mem_arbiter #(.NPORT(NPORT), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_addr    (req_addr),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .req_rdata   (req_rdata),
        .req_resp    (req_resp),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .err_timeout (err_timeout)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req_read  = '0;
        req_write = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Entered 2 time units into the first BUSY cycle; memory answers in BUSY cycle 'lat'.
    // Returns 3 time units into the following IDLE cycle.
    task automatic mem_txn(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [255:0] wdata, input int lat, input logic [255:0] rdata);
        logic [1:0] p;
        p = 2'd0;
        check_eq("exp_q_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) p = exp_q.pop_front();
        for (int c = 1; c <= lat; c++) begin
            if (c == lat) begin
                mem_resp  = 1'b1;
                mem_rdata = rdata;
            end
            #1;
            check_eq("mem_read", mem_read, rd);
            check_eq("mem_write", mem_write, wr);
            check_eq("mem_addr", mem_addr, addr);
            if (c < lat) begin
                check_eq("req_resp_wait", req_resp, 2'b00);
            end else begin
                check_eq("req_resp_done", req_resp, 2'b01 << p);
                check_eq("req_rdata0", req_rdata[0], rdata);
                check_eq("req_rdata1", req_rdata[1], rdata);
                if (wr) check_eq("mem_wdata", mem_wdata, wdata);
            end
            step();
        end
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #1;
        check_eq("idle_mem_read", mem_read, 1'b0);
        check_eq("idle_mem_write", mem_write, 1'b0);
        check_eq("idle_req_resp", req_resp, 2'b00);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        idle_inputs();

        // Reset state
        do_reset();
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_req_resp", req_resp, 2'b00);
        check_eq("rst_err", err_timeout, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 256'h0);

        // 1: single read from port 0, memory answers in the 5th BUSY cycle
        req_addr[0] = 32'h0000_1000;
        req_read[0] = 1'b1;
        #1;
        check_eq("t1_no_comb_path", mem_read, 1'b0);
        step();
        exp_q.push_back(2'd0);
        mem_txn(32'h0000_1000, 1'b1, 1'b0, '0, 5, {8{32'hC0DE_0001}});
        req_read = '0;

        // 2: simultaneous requests after reset, port 0 first, then port 1
        do_reset();
        req_addr[0] = 32'h0000_0100;
        req_addr[1] = 32'h0000_0200;
        req_read    = 2'b11;
        step();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        mem_txn(32'h0000_0100, 1'b1, 1'b0, '0, 2, {8{32'h1111_0002}});
        req_read[0] = 1'b0;
        step();
        mem_txn(32'h0000_0200, 1'b1, 1'b0, '0, 3, {8{32'h2222_0003}});
        req_read = '0;

        // 3: port 1 writeback then allocate on the same line slot
        req_addr[1]  = 32'h0000_2040;
        req_wdata[1] = {32{8'hA5}};
        req_write[1] = 1'b1;
        step();
        exp_q.push_back(2'd1);
        mem_txn(32'h0000_2040, 1'b0, 1'b1, {32{8'hA5}}, 3, '0);
        req_write[1] = 1'b0;
        req_read[1]  = 1'b1;
        req_addr[1]  = 32'h0000_3040;
        step();
        exp_q.push_back(2'd1);
        mem_txn(32'h0000_3040, 1'b1, 1'b0, '0, 2, {8{32'h3333_0004}});
        req_read = '0;

        // 4: port 1 continuously requesting, port 0 re-requesting each resp -> 0,1,0,1
        req_addr[0] = 32'h0000_4000;
        req_addr[1] = 32'h0000_5000;
        req_read    = 2'b11;
        step();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        mem_txn(32'h0000_4000, 1'b1, 1'b0, '0, 2, {8{32'h4444_0000}});
        req_addr[0] = 32'h0000_4020;
        step();
        mem_txn(32'h0000_5000, 1'b1, 1'b0, '0, 2, {8{32'h5555_0000}});
        req_addr[1] = 32'h0000_5020;
        step();
        mem_txn(32'h0000_4020, 1'b1, 1'b0, '0, 3, {8{32'h4444_0020}});
        req_addr[0] = 32'h0000_4040;
        step();
        mem_txn(32'h0000_5020, 1'b1, 1'b0, '0, 1, {8{32'h5555_0020}});
        req_read = '0;

        // 5: reset in the middle of a BUSY transaction
        req_addr[0] = 32'h0000_6000;
        req_read[0] = 1'b1;
        step();
        #1;
        check_eq("t5_busy_read", mem_read, 1'b1);
        rst_n    = 1'b0;
        mem_resp = 1'b1;
        #1;
        check_eq("t5_async_read", mem_read, 1'b0);
        check_eq("t5_async_addr", mem_addr, 32'h0);
        check_eq("t5_no_resp", req_resp, 2'b00);
        idle_inputs();
        step();
        step();
        rst_n       = 1'b1;
        req_addr[1] = 32'h0000_7000;
        req_read[1] = 1'b1;
        step();
        exp_q.push_back(2'd1);
        mem_txn(32'h0000_7000, 1'b1, 1'b0, '0, 2, {8{32'h7777_0005}});
        req_read = '0;

        // 6: watchdog with no memory response
        check_eq("t6_err_before", err_timeout, 1'b0);
        req_addr[0] = 32'h0000_8000;
        req_read[0] = 1'b1;
        step();
        for (int c = 1; c <= 9; c++) begin
            #1;
            check_eq($sformatf("t6_err_busy%0d", c), err_timeout, (c == 9));
            step();
        end
        mem_resp  = 1'b1;
        mem_rdata = {8{32'h9999_0006}};
        #1;
        check_eq("t6_late_resp", req_resp, 2'b01);
        check_eq("t6_err_at_resp", err_timeout, 1'b1);
        step();
        idle_inputs();
        #1;
        check_eq("t6_idle_read", mem_read, 1'b0);
        check_eq("t6_err_sticky", err_timeout, 1'b1);
        repeat (3) step();
        check_eq("t6_err_sticky_later", err_timeout, 1'b1);

        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
